// File: rtl/divisor_saturado_if.sv
// Handshake and data bundle for the saturating sequential divider.
// The Residuo signal exists only when DIVISOR_RESIDUO_EN is defined.
interface divisor_saturado_if #(
  parameter int Width = 8
);
  logic                    Start;
  logic signed [Width-1:0] OperandoA;
  logic signed [Width-1:0] OperandoB;
  logic                    Busy;
  logic                    Done;
  logic signed [Width-1:0] Result;
  logic                    Error;
`ifdef DIVISOR_RESIDUO_EN
  logic signed [Width-1:0] Residuo;

  modport slave (
    input  Start, OperandoA, OperandoB,
    output Busy, Done, Result, Error, Residuo
  );
  modport master (
    output Start, OperandoA, OperandoB,
    input  Busy, Done, Result, Error, Residuo
  );
`else
  modport slave (
    input  Start, OperandoA, OperandoB,
    output Busy, Done, Result, Error
  );
  modport master (
    output Start, OperandoA, OperandoB,
    input  Busy, Done, Result, Error
  );
`endif
endinterface

// File: rtl/divisor_saturado.sv
// Sequential signed restoring divider, one quotient bit per clock, with saturation and Error flag.
// Optional signed remainder output enabled by defining DIVISOR_RESIDUO_EN.
module divisor_saturado #(
  parameter int Width = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  divisor_saturado_if.slave bus
);

  localparam int CW = $clog2(Width + 1);
  localparam logic [Width-1:0] MAX_VAL = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MIN_VAL = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] mag_b_q, mag_b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [Width-1:0] result_q, result_d;
`ifdef DIVISOR_RESIDUO_EN
  logic [Width-1:0] op_a_q, op_a_d;
  logic [Width-1:0] residuo_q, residuo_d;
`endif

  logic [Width-1:0] mag_a_in, mag_b_in;
  logic [Width:0]   shifted, diff;
  logic             quo_neg;

  // |-2^(Width-1)| wraps to 2^(Width-1), which is still correct as an unsigned magnitude.
  assign mag_a_in = bus.OperandoA[Width-1] ? ('0 - $unsigned(bus.OperandoA)) : $unsigned(bus.OperandoA);
  assign mag_b_in = bus.OperandoB[Width-1] ? ('0 - $unsigned(bus.OperandoB)) : $unsigned(bus.OperandoB);

  assign shifted = {rem_q, quo_q[Width-1]};
  assign diff    = shifted - {1'b0, mag_b_q};
  assign quo_neg = sign_a_q ^ sign_b_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
`ifdef DIVISOR_RESIDUO_EN
    op_a_d    = op_a_q;
    residuo_d = residuo_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (bus.Start) begin
          state_d  = CALC;
          cnt_d    = CW'(Width);
          rem_d    = '0;
          quo_d    = mag_a_in;
          mag_b_d  = mag_b_in;
          sign_a_d = bus.OperandoA[Width-1];
          sign_b_d = bus.OperandoB[Width-1];
          b_zero_d = (bus.OperandoB == '0);
`ifdef DIVISOR_RESIDUO_EN
          op_a_d   = $unsigned(bus.OperandoA);
`endif
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (cnt_q != '0) begin
          // The dividend register doubles as the quotient register: bits shift out the top, quotient bits in the bottom.
          cnt_d = cnt_q - CW'(1);
          quo_d = {quo_q[Width-2:0], ~diff[Width]};
          rem_d = diff[Width] ? shifted[Width-1:0] : diff[Width-1:0];
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
          if (b_zero_q) begin
            result_d = sign_a_q ? MIN_VAL : MAX_VAL;
            error_d  = 1'b1;
          end else if (!quo_neg && quo_q[Width-1]) begin
            result_d = MAX_VAL;
            error_d  = 1'b1;
          end else begin
            result_d = quo_neg ? ('0 - quo_q) : quo_q;
            error_d  = 1'b0;
          end
`ifdef DIVISOR_RESIDUO_EN
          if (b_zero_q) begin
            residuo_d = op_a_q;
          end else begin
            residuo_d = sign_a_q ? ('0 - rem_q) : rem_q;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      mag_b_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      result_q  <= '0;
`ifdef DIVISOR_RESIDUO_EN
      op_a_q    <= '0;
      residuo_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mag_b_q   <= mag_b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      b_zero_q  <= b_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      result_q  <= result_d;
`ifdef DIVISOR_RESIDUO_EN
      op_a_q    <= op_a_d;
      residuo_q <= residuo_d;
`endif
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = $signed(result_q);
  assign bus.Error  = error_q;
`ifdef DIVISOR_RESIDUO_EN
  assign bus.Residuo = $signed(residuo_q);
`endif

endmodule

// File: doc/divisor_saturado.md
# divisor_saturado

Sequential signed integer divider with saturation and an error flag. It computes OperandoA / OperandoB, truncating toward zero, one quotient bit per clock. Results that cannot be represented, and division by zero, are clamped to the signed range and flagged on Error, using the same range and Error semantics as the team's saturating multiplier. It sits beside that multiplier in the matrix datapath and handles normalisation and scaling steps.

## Interface
- Width, 8, operand/result width in bits, two's complement; legal ≥ 2
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled on rising edge when accepting (IDLE or FIN)
- OperandoA  input  Width  signed dividend, captured when Start accepted
- OperandoB  input  Width  signed divisor, captured when Start accepted
- Busy  output  1  high while a division is in progress
- Done  output  1  one-cycle pulse, Result/Error valid
- Result  output  Width  signed saturated quotient, held until next Done
- Error  output  1  overflow or divide-by-zero of last op, held with Result
- Residuo  output  Width  signed remainder, only with DIVISOR_RESIDUO_EN

## Operation
- States: IDLE, CALC, FIN. Reset → IDLE.
- IDLE/FIN + Start=1 → CALC. Capture |A|, |B| as Width-bit unsigned magnitudes; |−2^(Width−1)| = 2^(Width−1) fits unsigned. Capture sign A, sign B, B==0 flag. Load iteration counter = Width.
- CALC: restoring division, one iteration per cycle. Shift the partial remainder left by one and bring in the next dividend MSB. Subtract |B| when the result is ≥ 0 and set the quotient bit. After Width iterations → FIN.
- FIN: lasts one cycle, then → IDLE unless Start=1, in which case → CALC. Result, Error and Residuo update on entry to FIN.
- Sign rule: quotient is negative iff sign A XOR sign B. Remainder takes the sign of A.
- Saturation, with max = 2^(Width−1)−1 and min = −2^(Width−1):
  - B==0, A≥0 → Result=max, Error=1
  - B==0, A<0 → Result=min, Error=1
  - Positive quotient with magnitude > max (only A=min, B=−1) → Result=max, Error=1
  - Otherwise Error=0 and Result = signed quotient exactly. A negative magnitude up to 2^(Width−1) is representable.
- Special cases run the full CALC sequence. Latency is constant, with no early termination.
- Start in CALC is ignored. Operand inputs are don't-care outside the accept cycle.

## Timing
- Reset values: Busy=0, Done=0, Result=0, Error=0, Residuo=0. State is IDLE and the counter is 0.
- Start accepted at edge 0. Busy=1 from edge 0 through edge Width. Done=1 and outputs valid after edge Width+1, for exactly one cycle.
- Latency is Width+1 cycles, Start edge to Done.
- Back-to-back: Start held high in the FIN cycle is accepted, with Busy=1 again after that edge. Throughput is one result per Width+1 cycles.
- Rst_n low mid-CALC: immediately clear all outputs and return to IDLE. The aborted operation produces no Done.
- Result, Error and Residuo change only on the Done edge or on reset.

## Configuration
- DIVISOR_RESIDUO_EN defined: the Residuo port exists and carries the signed remainder. A = Result·B + Residuo holds whenever Error=0. On divide-by-zero, Residuo = A.
- DIVISOR_RESIDUO_EN undefined: the Residuo port and its register are absent. Quotient behaviour is identical.

## Test plan
All scenarios use Width=8 unless noted.
- 100 / 7 → Done exactly 9 cycles after Start; Result=14, Error=0, Residuo=2. Check Busy high over edges 0–8.
- −100 / 7 → Result=−14, Residuo=−2, Error=0. Also 100 / −7 → −14, Residuo=2.
- −128 / −1 → Result=127, Error=1. Also −128 / 1 → −128, Error=0.
- 50 / 0 → Result=127, Error=1. Also −50 / 0 → Result=−128, Error=1, Residuo=−50.
- Start pulsed again in cycle 3 of 20 / 3 → ignored, single Done with Result=6. Start held high through FIN → second op accepted, next Done 9 cycles later.
- Rst_n low in cycle 4 of 90 / 9 → all outputs 0 immediately, no Done. Post-reset 90 / 9 → Result=10. Also run a random sign-mixed sweep for Width=4 against a reference model.
